// File: rtl/bus_trace_write_ctrl.sv
// Bus write tracer: queues CPU bus writes and streams each one to the trace sink as a
// 9-byte frame (sync, address MSB first, data MSB first) over a valid/ready byte link.
module bus_trace_write_ctrl #(
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_en,
  input  logic          bus_we,
  input  logic [31:0]   bus_addr,
  input  logic [31:0]   bus_wdata,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic [AW:0]   fifo_count,
  output logic [15:0]   drop_cnt,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [63:0]  mem_r [DEPTH];
  logic [AW-1:0] wptr_r, rptr_r;
  logic [AW:0]  count_r;
  logic [15:0]  drop_r;
  logic [63:0]  frame_r;
  logic [3:0]   idx_r;
  state_t       state_r;
  logic         out_valid_r;
  logic [7:0]   out_data_r;
  logic         busy_r;

  logic         wr_s, full_s, push_s, hs_s, last_s, pop_s;
  logic [AW:0]  count_nxt_s;
  state_t       state_nxt_s;

  function automatic logic [7:0] frame_byte(input logic [63:0] f, input logic [3:0] i);
    case (i)
      4'd0:    frame_byte = SYNC_BYTE;
      4'd1:    frame_byte = f[63:56];
      4'd2:    frame_byte = f[55:48];
      4'd3:    frame_byte = f[47:40];
      4'd4:    frame_byte = f[39:32];
      4'd5:    frame_byte = f[31:24];
      4'd6:    frame_byte = f[23:16];
      4'd7:    frame_byte = f[15:8];
      4'd8:    frame_byte = f[7:0];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // Push/pop decisions; full is judged on the registered count, never on a same-cycle pop.
  always_comb begin
    wr_s        = cap_en & bus_we;
    full_s      = (count_r == FULL_CNT);
    push_s      = wr_s & ~full_s;
    hs_s        = (state_r == SEND) & out_ready;
    last_s      = hs_s & (idx_r == 4'd8);
    pop_s       = (count_r != '0) & ((state_r == IDLE) | last_s);
    count_nxt_s = count_r;
    state_nxt_s = state_r;
    if (push_s & ~pop_s) begin
      count_nxt_s = count_r + (AW+1)'(1);
    end else if (pop_s & ~push_s) begin
      count_nxt_s = count_r - (AW+1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
    if (pop_s) begin
      state_nxt_s = SEND;
    end else if (last_s) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= {bus_addr, bus_wdata};
    end
  end

  // Pointers, counters, frame sequencer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      drop_r      <= 16'h0000;
      frame_r     <= 64'h0;
      idx_r       <= 4'd0;
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (wr_s & full_s & (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end
      // A pop loads the next frame directly, so frames chain with no idle gap.
      if (pop_s) begin
        frame_r    <= mem_r[rptr_r];
        rptr_r     <= rptr_r + AW'(1);
        idx_r      <= 4'd0;
        out_data_r <= SYNC_BYTE;
      end else if (last_s) begin
        idx_r      <= 4'd0;
        out_data_r <= 8'h00;
      end else if (hs_s) begin
        idx_r      <= idx_r + 4'd1;
        out_data_r <= frame_byte(frame_r, idx_r + 4'd1);
      end
      count_r     <= count_nxt_s;
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == SEND);
      busy_r      <= (state_nxt_s == SEND) | (count_nxt_s != '0);
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign fifo_count = count_r;
  assign drop_cnt   = drop_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_bus_trace_write_ctrl.sv
// Bench for bus_trace_write_ctrl: a queue-based model of the write log checked every
// cycle, plus directed scenarios with hand-computed byte sequences.
module tb_bus_trace_write_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst, cap_en, bus_we, out_ready;
  logic [31:0]   bus_addr, bus_wdata;
  logic          out_valid, busy;
  logic [7:0]    out_data;
  logic [AW:0]   fifo_count;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  logic [63:0] fq[$];
  logic [7:0]  cur[$];
  logic [15:0] m_drop = 16'h0;
  logic [7:0]  log_q[$];

  logic [7:0]  exp1 [9] = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

  bus_trace_write_ctrl #(.DEPTH(DEPTH), .AW(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: FIFO as a queue of entries, in-flight frame as the bytes still to send.
  always @(posedge clk) begin
    int n0;
    logic [63:0] e;
    if (rst) begin
      fq.delete();
      cur.delete();
      m_drop = 16'h0;
    end else begin
      n0 = fq.size();
      if (cur.size() == 0 || out_ready) begin
        if (cur.size() != 0) void'(cur.pop_front());
        if (cur.size() == 0 && n0 > 0) begin
          e = fq.pop_front();
          cur.push_back(8'hA5);
          for (int k = 0; k < 8; k++) cur.push_back(e[63-8*k -: 8]);
        end
      end
      if (cap_en && bus_we) begin
        if (n0 < DEPTH) fq.push_back({bus_addr, bus_wdata});
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
  end

  // Sink side: record every accepted byte.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) log_q.push_back(out_data);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic ev, eb;
    if (armed) begin
      ev = (cur.size() != 0);
      eb = ev || (fq.size() != 0);
      checks++;
      if (out_valid !== ev || (ev && out_data !== cur[0]) || fifo_count !== (AW+1)'(fq.size())
          || drop_cnt !== m_drop || busy !== eb) begin
        errors++;
        $display("FAIL cycle t=%0t dut/model: valid %b/%b data %h/%h count %0d/%0d drop %0d/%0d busy %b/%b",
                 $time, out_valid, ev, out_data, ev ? cur[0] : 8'h00, fifo_count, fq.size(),
                 drop_cnt, m_drop, busy, eb);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic write1(input logic [31:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    bus_we = 1'b0;
  endtask

  initial begin
    int run, best, t;
    bit seen;
    rst = 1'b1; cap_en = 1'b0; bus_we = 1'b0; out_ready = 1'b0;
    bus_addr = 32'h0; bus_wdata = 32'h0;
    step();
    armed = 1'b1;
    do_reset();
    chk("reset_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_data", {24'h0, out_data}, 32'h0);
    chk("reset_count", {28'h0, fifo_count}, 32'h0);
    chk("reset_drop", {16'h0, drop_cnt}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);

    // Single write with a free-running sink.
    cap_en = 1'b1; out_ready = 1'b1; log_q.delete();
    write1(32'h1000_0004, 32'hDEAD_BEEF);
    chk("single_count_e0", {28'h0, fifo_count}, 32'd1);
    chk("single_valid_e0", {31'h0, out_valid}, 32'd0);
    step();
    chk("single_valid_e1", {31'h0, out_valid}, 32'd1);
    chk("single_sync_e1", {24'h0, out_data}, 32'hA5);
    repeat (10) step();
    chk("single_len", log_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) chk("single_byte", {24'h0, (i < log_q.size()) ? log_q[i] : 8'hXX}, {24'h0, exp1[i]});
    chk("single_busy_end", {31'h0, busy}, 32'd0);

    // Back-pressure: ready pattern 1,0,0,1 repeating.
    log_q.delete();
    bus_we = 1'b1; bus_addr = 32'h1000_0004; bus_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
      bus_we = 1'b0;
    end
    chk("bp_len", log_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) chk("bp_byte", {24'h0, (i < log_q.size()) ? log_q[i] : 8'hXX}, {24'h0, exp1[i]});

    // Overflow: ten writes into a stalled sink.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) write1(32'h2000_0000 + i, 32'hC000_0000 + i);
    chk("ovf_count", {28'h0, fifo_count}, 32'd8);
    chk("ovf_drop", {16'h0, drop_cnt}, 32'd1);
    log_q.delete(); out_ready = 1'b1;
    repeat (100) step();
    chk("ovf_len", log_q.size(), 32'd81);
    for (int f = 0; f < 9 && 9*f+8 < log_q.size(); f++) begin
      chk("ovf_sync", {24'h0, log_q[9*f]}, 32'hA5);
      chk("ovf_addr_lsb", {24'h0, log_q[9*f+4]}, f);
      chk("ovf_data_lsb", {24'h0, log_q[9*f+8]}, f);
    end

    // Back-to-back frames: 18 consecutive valid cycles.
    log_q.delete(); run = 0; best = 0;
    write1(32'h3000_0000, 32'h0000_0011);
    write1(32'h3000_0001, 32'h0000_0022);
    for (int i = 0; i < 25; i++) begin
      run = out_valid ? run + 1 : 0;
      if (run > best) best = run;
      step();
    end
    chk("b2b_run", best, 32'd18);
    chk("b2b_len", log_q.size(), 32'd18);
    chk("b2b_second_sync", {24'h0, (log_q.size() > 9) ? log_q[9] : 8'h00}, 32'hA5);

    // Capture gating.
    do_reset();
    cap_en = 1'b0; seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write1(32'h4000_0000 + i, 32'h1);
      seen |= out_valid;
    end
    repeat (3) begin step(); seen |= out_valid; end
    chk("gate_novalid", {31'h0, seen}, 32'd0);
    chk("gate_count", {28'h0, fifo_count}, 32'd0);
    chk("gate_drop", {16'h0, drop_cnt}, 32'd0);
    cap_en = 1'b1; log_q.delete();
    write1(32'h1000_0004, 32'hDEAD_BEEF);
    step(); step();
    cap_en = 1'b0;
    repeat (12) step();
    chk("gate_midframe_len", log_q.size(), 32'd9);

    // Reset at byte 3 with two entries queued.
    cap_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) write1(32'h5000_0000 + i, 32'h5);
    t = 0;
    while (cur.size() != 6 && t < 20) begin step(); t++; end
    chk("rst_mid_reached", {31'h0, (cur.size() == 6)}, 32'd1);
    chk("rst_mid_queued", {28'h0, fifo_count}, 32'd2);
    do_reset();
    log_q.delete();
    chk("rst_mid_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_mid_count", {28'h0, fifo_count}, 32'd0);
    chk("rst_mid_drop", {16'h0, drop_cnt}, 32'd0);
    repeat (20) step();
    chk("rst_mid_silent", log_q.size(), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cap_en    = ($urandom % 4) != 0;
      bus_we    = ($urandom % 2) != 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 300) == 0;
      bus_addr  = $urandom;
      bus_wdata = $urandom;
      step();
    end
    rst = 1'b0; bus_we = 1'b0; out_ready = 1'b1;
    repeat (120) step();
    chk("drain_idle", {31'h0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
